// File: rtl/cdc_fifo_wr_arb_pkg.sv
// Shared definitions for the CDC FIFO write-port arbiter.
// Holds the FSM state encoding and the index-width helper that the
// arbiter top and its round-robin picker both rely on.
package cdc_fifo_wr_arb_pkg;

   // Two-state controller: waiting for a grant, or streaming a burst.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Bits needed to index n requesters; never narrower than one bit.
   function automatic int calcIdxW(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdc_fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker (module arb_rr_pick).
// Given a request vector and a start pointer, returns whether any request is
// set and the first set index at or after the pointer, wrapping modulo
// NUM_REQ. Pure logic, so other arbiters can reuse it unchanged.
module arb_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic               o_any,
   output logic [IDX_W-1:0]   o_idx
);

   logic found;
   int   j;

   // Scan from the pointer position, wrapping explicitly so that
   // non-power-of-two requester counts rotate correctly.
   always_comb begin
      o_any = |i_req;
      o_idx = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(i_ptr) + k) % NUM_REQ;
         if (!found && i_req[j]) begin
            found = 1'b1;
            o_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/cdc_fifo_wr_arb.sv
// Write-port arbiter for a CDC FIFO.
// NUM_REQ producers in the write clock domain share one FIFO write port.
// Grants are round-robin, each grant covers up to BURST_LEN words, a new
// burst only starts while the FIFO is not almost full, and the full flag
// stalls the active burst word by word.
// Optional feature: define CDC_FIFO_WR_ARB_PRIO_EN to give requester 0
// strict priority whenever a new burst is chosen.
module cdc_fifo_wr_arb
   import cdc_fifo_wr_arb_pkg::*;
#(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 8,
   parameter int  BURST_LEN  = 4,
   localparam int IDX_W      = calcIdxW(NUM_REQ)
) (
   input  logic                          w_clk,
   input  logic                          w_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          w_full,
   input  logic                          w_almost_full,
   output logic                          w_inc,
   output logic [DATA_WIDTH-1:0]         w_data,
   output logic [IDX_W-1:0]              grant_id,
   output logic                          busy
);

   localparam int CNT_W = $clog2(BURST_LEN) + 1;

   state_t             r_state;
   logic [IDX_W-1:0]   r_grantId;
   logic [IDX_W-1:0]   r_rrPtr;
   logic [CNT_W-1:0]   r_beatCnt;

   state_t             w_nextState;
   logic [IDX_W-1:0]   w_nextGrant;
   logic [IDX_W-1:0]   w_nextRrPtr;
   logic [CNT_W-1:0]   w_nextBeat;

   logic               w_rrAny;
   logic [IDX_W-1:0]   w_rrIdx;
   logic [IDX_W-1:0]   w_pickIdx;
   logic [IDX_W-1:0]   w_grantPlusOne;
   logic               w_selValid;
   logic               w_xfer;
   logic               w_lastBeat;
   logic [DATA_WIDTH-1:0] w_reqWords [NUM_REQ];

   // Split the flat data bus into one word per requester for clean muxing.
   for (genvar g = 0; g < NUM_REQ; g++) begin : gen_words
      assign w_reqWords[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .i_req (req_valid),
      .i_ptr (r_rrPtr),
      .o_any (w_rrAny),
      .o_idx (w_rrIdx)
   );

   // Choose the next grantee; with the priority feature requester 0 wins
   // outright, otherwise the round-robin pick stands.
   always_comb begin
`ifdef CDC_FIFO_WR_ARB_PRIO_EN
      w_pickIdx = req_valid[0] ? '0 : w_rrIdx;
`else
      w_pickIdx = w_rrIdx;
`endif
   end

   // Per-cycle handshake terms for the current grantee.
   always_comb begin
      w_selValid     = req_valid[r_grantId];
      w_xfer         = (r_state == ST_BURST) && w_selValid && !w_full;
      w_lastBeat     = (r_beatCnt == CNT_W'(BURST_LEN - 1));
      w_grantPlusOne = (r_grantId == IDX_W'(NUM_REQ - 1)) ? '0 : r_grantId + IDX_W'(1);
   end

   // Next-state and output decode; the write strobe and data are combinational
   // so the full flag stalls the burst in the same cycle it is seen.
   always_comb begin
      w_nextState = r_state;
      w_nextGrant = r_grantId;
      w_nextRrPtr = r_rrPtr;
      w_nextBeat  = r_beatCnt;
      busy        = 1'b0;
      w_inc       = 1'b0;
      w_data      = '0;
      req_ready   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_rrAny && !w_almost_full) begin
               w_nextState = ST_BURST;
               w_nextGrant = w_pickIdx;
               w_nextBeat  = '0;
            end
         end
         ST_BURST: begin
            busy = 1'b1;
            if (!w_full) begin
               req_ready[r_grantId] = 1'b1;
            end
            if (w_xfer) begin
               w_inc      = 1'b1;
               w_data     = w_reqWords[r_grantId];
               w_nextBeat = r_beatCnt + CNT_W'(1);
            end
            if (!w_selValid || (w_xfer && w_lastBeat)) begin
               w_nextState = ST_IDLE;
               w_nextGrant = '0;
               w_nextBeat  = '0;
`ifdef CDC_FIFO_WR_ARB_PRIO_EN
               if (r_grantId != '0) begin
                  w_nextRrPtr = w_grantPlusOne;
               end
`else
               w_nextRrPtr = w_grantPlusOne;
`endif
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Controller registers; reset can land mid-burst and simply abandons it.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= ST_IDLE;
         r_grantId <= '0;
         r_rrPtr   <= '0;
         r_beatCnt <= '0;
      end else begin
         r_state   <= w_nextState;
         r_grantId <= w_nextGrant;
         r_rrPtr   <= w_nextRrPtr;
         r_beatCnt <= w_nextBeat;
      end
   end

   assign grant_id = r_grantId;

endmodule

// File: tb/tb_cdc_fifo_wr_arb.sv
// Directed self-checking bench for cdc_fifo_wr_arb (NUM_REQ=4, BURST_LEN=4).
// Each requester i offers words 0x10*i + n, n counting accepted words, so the
// expected FIFO data of every beat follows from the requester and beat index.
module tb_cdc_fifo_wr_arb;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int BURST_LEN  = 4;

   logic                          w_clk;
   logic                          w_rst_n;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          w_full;
   logic                          w_almost_full;
   logic                          w_inc;
   logic [DATA_WIDTH-1:0]         w_data;
   logic [1:0]                    grant_id;
   logic                          busy;

   int    nAsserts;
   int    nFail;
   int    remaining [NUM_REQ];
   int    sent      [NUM_REQ];
   string phase;

   cdc_fifo_wr_arb #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .BURST_LEN  (BURST_LEN)
   ) dut (
      .w_clk         (w_clk),
      .w_rst_n       (w_rst_n),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .w_full        (w_full),
      .w_almost_full (w_almost_full),
      .w_inc         (w_inc),
      .w_data        (w_data),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   // Free-running write clock.
   initial begin
      w_clk = 1'b0;
      forever #5 w_clk = ~w_clk;
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no end of test, expected end before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
      end
   endtask

   task automatic setReq(input int i, input int n);
      remaining[i] = n;
      sent[i]      = 0;
   endtask

   task automatic driveProducers();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (remaining[i] > 0);
         req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'(16*i + sent[i]);
      end
   endtask

   task automatic checkAllZero();
      checkOutput("busy",  32'(busy),      32'd0);
      checkOutput("grant", 32'(grant_id),  32'd0);
      checkOutput("inc",   32'(w_inc),     32'd0);
      checkOutput("data",  32'(w_data),    32'd0);
      checkOutput("ready", 32'(req_ready), 32'd0);
   endtask

   // One clock of stimulus and checking, entered just after a rising edge.
   task automatic applyStimulus(input logic eBusy, input int eGid, input logic eInc,
                                input int eData, input int eReady);
      logic [NUM_REQ-1:0] xfer;
      driveProducers();
      #1;
      checkOutput("busy",  32'(busy),      32'(eBusy));
      checkOutput("grant", 32'(grant_id),  32'(eGid));
      checkOutput("inc",   32'(w_inc),     32'(eInc));
      checkOutput("data",  32'(w_data),    32'(eData));
      checkOutput("ready", 32'(req_ready), 32'(eReady));
      xfer = req_valid & req_ready;
      @(posedge w_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (xfer[i]) begin
            remaining[i]--;
            sent[i]++;
         end
      end
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 0, 1'b0, 0, 0);
   endtask

   task automatic beat(input int g, input int n);
      applyStimulus(1'b1, g, 1'b1, 16*g + n, 1 << g);
   endtask

   task automatic doReset();
      w_rst_n = 1'b0;
      @(posedge w_clk);
      #1;
      w_rst_n = 1'b1;
   endtask

   initial begin
      int g;
      int n;
      nAsserts      = 0;
      nFail         = 0;
      w_rst_n       = 1'b0;
      req_valid     = '0;
      req_data      = '0;
      w_full        = 1'b0;
      w_almost_full = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 0);

      // Reset state.
      phase = "reset";
      repeat (2) @(posedge w_clk);
      #1;
      checkAllZero();
      w_rst_n = 1'b1;

      // Requester 2 alone, 10 words: bursts of 4, 4, 2 with idle gaps.
      phase = "single";
      setReq(2, 10);
      for (int b = 0; b < 2; b++) begin
         idleCycle();
         for (int k = 0; k < 4; k++) beat(2, 4*b + k);
      end
      idleCycle();
      beat(2, 8);
      beat(2, 9);
      applyStimulus(1'b1, 2, 1'b0, 0, 4);
      idleCycle();

      // All four valid: grants rotate 0,1,2,3,0 with exactly 4 beats each.
      phase = "allvalid";
      doReset();
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 100);
      for (int b = 0; b < 5; b++) begin
         idleCycle();
         for (int k = 0; k < 4; k++) begin
`ifdef CDC_FIFO_WR_ARB_PRIO_EN
            g = 0;
            n = 4*b + k;
`else
            g = b % 4;
            n = (b / 4) * 4 + k;
`endif
            beat(g, n);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 0);
      idleCycle();

      // Full for 3 cycles mid-burst: stall without counting beats.
      phase = "fullstall";
      setReq(1, 4);
      idleCycle();
      beat(1, 0);
      beat(1, 1);
      w_full = 1'b1;
      repeat (3) applyStimulus(1'b1, 1, 1'b0, 0, 0);
      w_full = 1'b0;
      beat(1, 2);
      beat(1, 3);
      idleCycle();

      // Almost full in idle blocks grants; rising mid-burst does not cut it.
      phase = "afull";
      for (int i = 0; i < NUM_REQ; i++) setReq(i, 4);
      w_almost_full = 1'b1;
      repeat (3) idleCycle();
      setReq(0, 0);
      setReq(1, 0);
      w_almost_full = 1'b0;
      idleCycle();
      beat(2, 0);
      w_almost_full = 1'b1;
      beat(2, 1);
      beat(2, 2);
      beat(2, 3);
      repeat (2) idleCycle();
      setReq(3, 0);
      w_almost_full = 1'b0;
      idleCycle();

      // Requester 1 drops valid after 2 words; next grant goes to 2.
      phase = "drop";
      setReq(1, 2);
      setReq(2, 4);
      idleCycle();
      beat(1, 0);
      beat(1, 1);
      applyStimulus(1'b1, 1, 1'b0, 0, 2);
      idleCycle();
      beat(2, 0);
      beat(2, 1);

      // Asynchronous reset mid-burst: outputs clear at once, pointer returns to 0.
      phase = "asyncrst";
      driveProducers();
      #2;
      w_rst_n = 1'b0;
      #1;
      checkAllZero();
      @(posedge w_clk);
      #1;
      w_rst_n = 1'b1;
      setReq(2, 0);
      setReq(1, 4);
      setReq(3, 4);
      idleCycle();
      for (int k = 0; k < 4; k++) beat(1, k);
      idleCycle();
      for (int k = 0; k < 4; k++) beat(3, k);
      idleCycle();

`ifdef CDC_FIFO_WR_ARB_PRIO_EN
      // Requester 0 keeps winning while valid; requester 3 follows afterwards.
      phase = "prio";
      doReset();
      setReq(0, 8);
      setReq(3, 4);
      for (int b = 0; b < 2; b++) begin
         idleCycle();
         for (int k = 0; k < 4; k++) beat(0, 4*b + k);
      end
      idleCycle();
      for (int k = 0; k < 4; k++) beat(3, k);
      idleCycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
